muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit for the EX stage of the MIPS core. It decodes the 8-bit `alucontrol` codes for MULT/MULTU/DIV/DIVU/MTHI/MTLO that the ALU decoder emits, and owns the architectural HI/LO registers. It stalls the pipeline while an operation is in flight. Width is parametrised; division is iterative radix-2 and can be compiled out.

---
 rtl/muldiv_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Define MDU_DIV_EN to build the radix-2 restoring divider (DIV/DIVU).
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int OPW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [OPW-1:0]   alucontrol_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [OPW-1:0] OP_MULT  = OPW'(8'b00011000);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(8'b00011001);
    localparam logic [OPW-1:0] OP_MTHI  = OPW'(8'b00010001);
    localparam logic [OPW-1:0] OP_MTLO  = OPW'(8'b00010011);
`ifdef MDU_DIV_EN
    localparam logic [OPW-1:0] OP_DIV   = OPW'(8'b00011010);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(8'b00011011);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
`endif

`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
`ifdef MDU_DIV_EN
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    logic op_mul, op_div, op_sgn, op_mthi, op_mtlo;
    logic can_acc;

    assign op_mul  = (alucontrol_i == OP_MULT) ||
                     (alucontrol_i == OP_MULTU);
    assign op_mthi = (alucontrol_i == OP_MTHI);
    assign op_mtlo = (alucontrol_i == OP_MTLO);
`ifdef MDU_DIV_EN
    assign op_div  = (alucontrol_i == OP_DIV) ||
                     (alucontrol_i == OP_DIVU);
    assign op_sgn  = (alucontrol_i == OP_MULT) ||
                     (alucontrol_i == OP_DIV);
`else
    assign op_div  = 1'b0;
    assign op_sgn  = (alucontrol_i == OP_MULT);
`endif

    assign can_acc = (state_q == S_IDLE) || (state_q == S_DONE);
`ifdef MDU_DIV_EN
    assign busy_o  = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy_o  = (state_q == S_MUL);
`endif
    assign stall_o = busy_o | (valid_i & (op_mul | op_div) & can_acc);
    assign done_o  = (state_q == S_DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    // Sign-extending to 2*WIDTH lets one multiplier serve both MULT and MULTU.
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign prod  = a_ext * b_ext;

`ifdef MDU_DIV_EN
    // Divide-by-zero rides the MUL state so it shares the 2-cycle latency.
    assign res_hi = dz_q ? a_q : prod[2*WIDTH-1:WIDTH];
    assign res_lo = dz_q ? '1  : prod[WIDTH-1:0];

    logic [WIDTH:0]   shl, diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx, quo_nx, a_mag, b_mag;

    // a_q holds the dividend shifting out and the quotient shifting in.
    assign shl    = {rem_q, a_q[WIDTH-1]};
    assign diff   = shl - {1'b0, b_q};
    assign q_bit  = ~diff[WIDTH];
    assign rem_nx = q_bit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    assign quo_nx = {a_q[WIDTH-2:0], q_bit};
    assign a_mag  = (op_sgn & a_i[WIDTH-1]) ? ~a_i + ONE : a_i;
    assign b_mag  = (op_sgn & b_i[WIDTH-1]) ? ~b_i + ONE : b_i;
`else
    assign res_hi = prod[2*WIDTH-1:WIDTH];
    assign res_lo = prod[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
`ifdef MDU_DIV_EN
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (valid_i && !flush_i) begin
                    unique case (1'b1)
                        op_mul: begin
                            state_d = S_MUL;
                            a_d     = a_i;
                            b_d     = b_i;
                            sgn_d   = op_sgn;
`ifdef MDU_DIV_EN
                            dz_d    = 1'b0;
`endif
                        end
`ifdef MDU_DIV_EN
                        op_div: begin
                            sgn_d = op_sgn;
                            if (b_i == '0) begin
                                state_d = S_MUL;
                                dz_d    = 1'b1;
                                a_d     = a_i;
                            end else begin
                                state_d = S_DIV;
                                dz_d    = 1'b0;
                                a_d     = a_mag;
                                b_d     = b_mag;
                                rem_d   = '0;
                                cnt_d   = 6'(WIDTH-1);
                                qneg_d  = op_sgn &
                                          (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                                rneg_d  = op_sgn & a_i[WIDTH-1];
                            end
                        end
`endif
                        op_mthi: begin
                            hi_d    = a_i;
                            state_d = S_DONE;
                        end
                        op_mtlo: begin
                            lo_d    = a_i;
                            state_d = S_DONE;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = S_DONE;
                end
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_nx;
                    a_d   = quo_nx;
                    if (cnt_q == 6'd0) begin
                        state_d = S_DONE;
                        lo_d    = qneg_q ? ~quo_nx + ONE : quo_nx;
                        hi_d    = rneg_q ? ~rem_nx + ONE : rem_nx;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
`ifdef MDU_DIV_EN
            cnt_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
`ifdef MDU_DIV_EN
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Driver pushes expected HI/LO/done-cycle; a negedge monitor pops on done_o.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_DIV   = 8'b00011010;
    localparam logic [7:0] OP_DIVU  = 8'b00011011;
    localparam logic [7:0] OP_MTHI  = 8'b00010001;
    localparam logic [7:0] OP_MTLO  = 8'b00010011;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic         flush_i;
    logic [7:0]   op;
    logic [W-1:0] a, b;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W), .OPW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .alucontrol_i (op),
        .a_i          (a),
        .b_i          (b),
        .flush_i      (flush_i),
        .busy_o       (busy),
        .stall_o      (stall),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           at;
        string        tag;
    } exp_t;

    exp_t         q[$];
    int           tests = 0;
    int           fails = 0;
    int           dones = 0;
    int           d0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         st_acc;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            dones++;
            if (q.size() == 0) begin
                chk("unexpected done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk({e.tag, " hi"}, hi, e.hi);
                chk({e.tag, " lo"}, lo, e.lo);
                chk({e.tag, " cycle"}, cyc, e.at);
            end
        end
    end

    // lat < 0: no completion expected.
    task automatic issue(input logic [7:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int lat,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input string tag);
        op      = o;
        a       = x;
        b       = y;
        valid_i = 1'b1;
        if (lat >= 0) begin
            q.push_back('{eh, el, cyc + 1 + lat, tag});
            m_hi = eh;
            m_lo = el;
        end
        @(negedge clk);
        st_acc = stall;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        op = '0; a = '0; b = '0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        idle(1);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 1,
              32'hFFFFFFFF, 32'hFFFFFFF1, "mult");
        chk("mult stall accept", 32'(st_acc), 32'd1);
        drain();

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,
              32'hFFFFFFFE, 32'h00000001, "multu");
        chk("multu stall accept", 32'(st_acc), 32'd1);
        @(negedge clk);
        chk("multu stall mul", 32'(stall), 32'd1);
        chk("multu busy mul", 32'(busy), 32'd1);
        @(negedge clk);
        chk("multu stall done", 32'(stall), 32'd0);
        chk("multu busy done", 32'(busy), 32'd0);
        drain();

        issue(OP_MTHI, 32'hAA, 32'd0, 0, 32'hAA, m_lo, "mthi");
        chk("mthi stall", 32'(st_acc), 32'd0);
        issue(OP_MTLO, 32'h55, 32'd0, 0, 32'hAA, 32'h55, "mtlo");
        issue(OP_MULT, 32'd2, 32'd3, 1, 32'd0, 32'd6, "mult b2b");
        drain();

        d0 = dones;
        issue(OP_MULT, 32'd6, 32'd7, 1, 32'd0, 32'd42, "mult busy");
        op = OP_MTHI; a = 32'hDEAD; valid_i = 1'b1;
        @(negedge clk);
        chk("stall while busy", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        drain();
        idle(3);
        chk("busy req hi", hi, 32'd0);
        chk("busy req lo", lo, 32'd42);
        chk("busy req dones", 32'(dones - d0), 32'd1);

        d0 = dones;
        issue(OP_MULT, 32'd9, 32'd9, -1, '0, '0, "flush mul");
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush mul busy", 32'(busy), 32'd0);
        idle(4);
        chk("flush mul dones", 32'(dones - d0), 32'd0);
        chk("flush mul hi", hi, m_hi);
        chk("flush mul lo", lo, m_lo);

        d0 = dones;
        op = OP_MTHI; a = 32'h77; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0; flush_i = 1'b0;
        idle(3);
        chk("flush idle dones", 32'(dones - d0), 32'd0);
        chk("flush idle hi", hi, m_hi);

        d0 = dones;
        op = 8'h20; a = 32'h11; b = 32'h22; valid_i = 1'b1;
        @(negedge clk);
        chk("unknown stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        idle(3);
        chk("unknown dones", 32'(dones - d0), 32'd0);
        chk("unknown busy", 32'(busy), 32'd0);

`ifdef MDU_DIV_EN
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, W,
              32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        chk("div stall accept", 32'(st_acc), 32'd1);
        drain();
        issue(OP_DIVU, 32'd100, 32'd7, W, 32'd2, 32'd14, "divu");
        drain();
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, W,
              32'd1, 32'hFFFFFFFD, "div negb");
        drain();
        issue(OP_DIVU, 32'h1234, 32'd0, 1,
              32'h1234, 32'hFFFFFFFF, "div0");
        drain();

        d0 = dones;
        issue(OP_DIV, 32'd1000, 32'd3, -1, '0, '0, "div flush");
        idle(9);
        chk("div busy before flush", 32'(busy), 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("div flush busy", 32'(busy), 32'd0);
        idle(40);
        chk("div flush dones", 32'(dones - d0), 32'd0);
        chk("div flush hi", hi, m_hi);
        chk("div flush lo", lo, m_lo);

        d0 = dones;
        issue(OP_DIV, 32'd1000, 32'd3, -1, '0, '0, "div rst");
        idle(9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("div rst hi", hi, 32'd0);
        chk("div rst lo", lo, 32'd0);
        chk("div rst busy", 32'(busy), 32'd0);
        idle(40);
        chk("div rst dones", 32'(dones - d0), 32'd0);
`else
        d0 = dones;
        op = OP_DIV; a = 32'd100; b = 32'd7; valid_i = 1'b1;
        @(negedge clk);
        chk("nodiv stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("nodiv busy", 32'(busy), 32'd0);
        idle(40);
        chk("nodiv dones", 32'(dones - d0), 32'd0);
        chk("nodiv hi", hi, m_hi);
        chk("nodiv lo", lo, m_lo);

        d0 = dones;
        issue(OP_MULT, 32'd5, 32'd5, -1, '0, '0, "mul rst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("mul rst hi", hi, 32'd0);
        chk("mul rst lo", lo, 32'd0);
        chk("mul rst busy", 32'(busy), 32'd0);
        idle(4);
        chk("mul rst dones", 32'(dones - d0), 32'd0);
`endif

        issue(OP_MULTU, 32'h10000, 32'h10000, 1,
              32'd1, 32'd0, "multu post rst");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
